// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; start, WIDTH data bits MSB first, even parity, stop.
// Define UART_RX_MAJORITY_EN to vote each bit 2-of-3 around the bit centre.
module uart_rx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk_baud,
  input  logic             rst,
  input  logic             rx_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             rx_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             rx_busy
);

  localparam int unsigned PhW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BcW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned Mid = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned Decide = Mid + 1;
`else
  localparam int unsigned Decide = Mid;
`endif
  localparam logic [PhW-1:0] PhDecide = PhW'(Decide);
  localparam logic [PhW-1:0] PhLast   = PhW'(OVERSAMPLE - 1);
  localparam logic [BcW-1:0] BcLast   = BcW'(WIDTH - 1);

  typedef enum logic [2:0] {StHunt, StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q;
  logic [PhW-1:0]   phase_q;
  logic [BcW-1:0]   bit_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_bad_q;
  logic             sync_q, rxs, rxs_prev;
  logic             sample;
  logic             at_decide;

  // Synchronizer and edge-detect history preset to the idle line level.
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      sync_q   <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync_q   <= rx_in;
      rxs      <= sync_q;
      rxs_prev <= rxs;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // hist_q holds rxs from phases MID-1 and MID when the vote is taken at MID+1.
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxs};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign sample = rxs;
`endif

  assign rx_busy   = (state_q != StHunt) && (state_q != StIdle);
  assign at_decide = (phase_q == PhDecide);

  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state_q    <= StHunt;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      bus_out    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_busy) begin
        phase_q <= (phase_q == PhLast) ? '0 : phase_q + 1'b1;
      end else begin
        phase_q <= '0;
      end
      unique case (state_q)
        StHunt: begin
          if (rxs) state_q <= StIdle;
        end
        StIdle: begin
          if (rxs_prev && !rxs) state_q <= StStart;
        end
        StStart: begin
          if (at_decide) begin
            // A high sample at mid-start is a glitch, not a frame.
            state_q   <= sample ? StIdle : StData;
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (at_decide) begin
            shift_q <= WIDTH'({shift_q, sample});
            if (bit_cnt_q == BcLast) begin
              state_q <= StParity;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (at_decide) begin
            par_bad_q <= sample ^ (^shift_q);
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (at_decide) begin
            bus_out <= shift_q;
            if (!sample) begin
              frame_err <= 1'b1;
              state_q   <= StHunt;
            end else begin
              parity_err <= par_bad_q;
              rx_valid   <= !par_bad_q;
              state_q    <= StIdle;
            end
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

endmodule
